// File: rtl/polar_psum_unit.sv
// rtl/polar_psum_unit.sv - SC polar decoder partial-sum unit with codeword re-encode
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, n_cfg            begin a frame of length 2^n_cfg (0 or >LOG_N means LOG_N)
//   u_valid, u_in, u_ready  decided-bit input handshake, one bit per cycle
//   bit_idx_o               index of the next bit to be accepted
//   psum_o                  packed level registers, P_k at [2^(k+1)-2 : 2^k-1]
//   psum_upd_o              bit k set when P_k was rewritten by the last accepted bit
//   cw_valid, cw_ack, cw_o  re-encoded codeword handshake (low 2^n bits meaningful)
module polar_psum_unit #(
  parameter int LOG_N = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(LOG_N+1)-1:0]   n_cfg,
  input  logic                         u_valid,
  input  logic                         u_in,
  output logic                         u_ready,
  output logic [LOG_N-1:0]             bit_idx_o,
  output logic [(1<<LOG_N)-2:0]        psum_o,
  output logic [LOG_N-1:0]             psum_upd_o,
  output logic                         cw_valid,
  input  logic                         cw_ack,
  output logic [(1<<LOG_N)-1:0]        cw_o
);

  localparam int NMAX = 1 << LOG_N;
  localparam int PW   = NMAX - 1;
  localparam int NCW  = $clog2(LOG_N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [NCW-1:0]    n_q;
  logic [LOG_N-1:0]  i_q;
  logic [PW-1:0]     psum_q;
  logic [LOG_N-1:0]  upd_q;
  logic [NMAX-1:0]   cw_q;

  logic [NCW-1:0]    n_eff;
  logic              accept;
  logic              last;
  logic [NMAX-1:0]   e;
  logic [NMAX-1:0]   pk;
  logic [NMAX-1:0]   wmask;
  logic [NMAX-1:0]   cw_d;
  logic [PW-1:0]     lvl_mask;
  logic [PW-1:0]     psum_d;
  logic [LOG_N-1:0]  upd_d;
  logic [LOG_N-1:0]  lowm;

  assign n_eff  = (n_cfg == '0 || int'(n_cfg) > LOG_N) ? NCW'(LOG_N) : n_cfg;
  assign accept = (state_q == S_RUN) && u_valid;
  assign last   = (int'(i_q) == (1 << int'(n_q)) - 1);

  // Encoding chain. e holds E_k in its low 2^k bits at the top of iteration k.
  // E_k is always computed; whether it is stored depends on the trailing ones
  // of i, so the chain itself needs no early exit.
  always_comb begin
    e        = NMAX'(u_in);
    psum_d   = psum_q;
    upd_d    = '0;
    cw_d     = '0;
    pk       = '0;
    wmask    = '0;
    lvl_mask = '0;
    lowm     = '0;
    for (int k = 0; k < LOG_N; k++) begin
      if (k == int'(n_q)) cw_d = e;
      wmask    = {NMAX{1'b1}} >> (NMAX - (1 << k));
      lvl_mask = PW'(wmask << ((1 << k) - 1));
      lowm     = LOG_N'((1 << k) - 1);
      if (k < int'(n_q) && (i_q & lowm) == lowm) begin
        psum_d   = (psum_d & ~lvl_mask) | (PW'(e << ((1 << k) - 1)) & lvl_mask);
        upd_d[k] = 1'b1;
      end
      // Old P_k feeds the next level; the update above only affects psum_d.
      pk = (NMAX'(psum_q) >> ((1 << k) - 1)) & wmask;
      e  = (e << (1 << k)) | (pk ^ e);
    end
    if (int'(n_q) == LOG_N) cw_d = e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN:  if (accept && last) state_d = S_DONE;
        S_DONE: if (cw_ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    u_ready  = 1'b0;
    cw_valid = 1'b0;
    case (state_q)
      S_RUN:  u_ready  = 1'b1;
      S_DONE: cw_valid = 1'b1;
      default: ;
    endcase
  end

  // start wins over a same-cycle bit, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      i_q    <= '0;
      psum_q <= '0;
      upd_q  <= '0;
      cw_q   <= '0;
    end else if (start) begin
      n_q    <= n_eff;
      i_q    <= '0;
      psum_q <= '0;
      upd_q  <= '0;
      cw_q   <= '0;
    end else if (accept) begin
      psum_q <= psum_d;
      upd_q  <= upd_d;
      if (last) begin
        i_q  <= '0;
        cw_q <= cw_d;
      end else begin
        i_q  <= i_q + 1'b1;
      end
    end else begin
      upd_q  <= '0;
    end
  end

  assign bit_idx_o  = i_q;
  assign psum_o     = psum_q;
  assign psum_upd_o = upd_q;
  assign cw_o       = cw_q;

endmodule

// File: tb/tb_polar_psum_unit.sv
// tb/tb_polar_psum_unit.sv - directed vector bench for polar_psum_unit
module tb_polar_psum_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   n_cfg;
  logic         u_valid;
  logic         u_in;
  logic         u_ready;
  logic [7:0]   bit_idx_o;
  logic [254:0] psum_o;
  logic [7:0]   psum_upd_o;
  logic         cw_valid;
  logic         cw_ack;
  logic [255:0] cw_o;

  int n_run  = 0;
  int n_fail = 0;

  polar_psum_unit #(.LOG_N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_cfg(n_cfg),
    .u_valid(u_valid), .u_in(u_in), .u_ready(u_ready),
    .bit_idx_o(bit_idx_o), .psum_o(psum_o), .psum_upd_o(psum_upd_o),
    .cw_valid(cw_valid), .cw_ack(cw_ack), .cw_o(cw_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         st;
    logic [3:0]   n;
    logic         v;
    logic         u;
    logic         ack;
    logic         rdy;
    logic [7:0]   idx;
    logic [254:0] psum;
    logic [7:0]   upd;
    logic         cwv;
    logic [255:0] cw;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input int st, input int n, input int v, input int u, input int ack,
                              input int rdy, input int idx, input int ps, input int upd,
                              input int cwv, input int cw);
    vec_t r;
    r.st = st[0]; r.n = n[3:0]; r.v = v[0]; r.u = u[0]; r.ack = ack[0];
    r.rdy = rdy[0]; r.idx = idx[7:0]; r.psum = 255'(ps); r.upd = upd[7:0];
    r.cwv = cwv[0]; r.cw = 256'(cw);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, return at next negedge.
  task automatic cyc(input logic st, input logic [3:0] n, input logic v, input logic u, input logic ack);
    start = st; n_cfg = n; u_valid = v; u_in = u; cw_ack = ack;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; u_valid = 1'b0; cw_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [255:0] top1;
  int           accepted;
  logic [3:0]   ncase [2];

  initial begin
    top1 = '0;
    top1[255] = 1'b1;
    ncase[0] = 4'd0;
    ncase[1] = 4'd15;

    //         st n v u a | rdy idx ps upd cwv cw
    tbl.push_back(mk(1,2,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,0, 1,1,1,1,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,2,2,3,0,0));
    tbl.push_back(mk(0,0,1,1,0, 1,3,3,1,0,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,5,3,1,'hB));
    tbl.push_back(mk(0,0,0,0,0, 0,0,5,0,1,'hB));
    tbl.push_back(mk(0,0,1,1,0, 0,0,5,0,1,'hB));
    tbl.push_back(mk(0,0,0,0,1, 0,0,5,0,0,'hB));
    tbl.push_back(mk(0,0,1,1,0, 0,0,5,0,0,'hB));
    tbl.push_back(mk(1,1,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,0, 1,1,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,1,1,0,0,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,1,1,1,2));
    for (int j = 0; j < 5; j++) tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,1,2));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,0,2));
    tbl.push_back(mk(1,2,1,1,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,0, 1,1,1,1,0,0));
    tbl.push_back(mk(1,2,1,1,1, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0));

    rst_n = 1'b0; start = 1'b0; n_cfg = '0; u_valid = 1'b0; u_in = 1'b0; cw_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset u_ready", u_ready, 0);
    chk("reset bit_idx", bit_idx_o, 0);
    chk("reset psum", psum_o, 0);
    chk("reset upd", psum_upd_o, 0);
    chk("reset cw_valid", cw_valid, 0);
    chk("reset cw", cw_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].n, tbl[i].v, tbl[i].u, tbl[i].ack);
      chk($sformatf("vec%0d u_ready", i), u_ready, tbl[i].rdy);
      chk($sformatf("vec%0d bit_idx", i), bit_idx_o, tbl[i].idx);
      chk($sformatf("vec%0d psum", i), psum_o, tbl[i].psum);
      chk($sformatf("vec%0d upd", i), psum_upd_o, tbl[i].upd);
      chk($sformatf("vec%0d cw_valid", i), cw_valid, tbl[i].cwv);
      chk($sformatf("vec%0d cw", i), cw_o, tbl[i].cw);
    end

    // n=8, all ones with random idle gaps
    cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    accepted = 0;
    while (accepted < 256) begin
      chk($sformatf("ones idx@%0d", accepted), bit_idx_o, 256'(accepted[7:0]));
      if ($urandom_range(0, 3) == 0) begin
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("ones gap upd", psum_upd_o, 0);
      end else begin
        cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        accepted++;
      end
    end
    chk("ones cw", cw_o, top1);
    chk("ones cw_valid", cw_valid, 1);
    chk("ones u_ready", u_ready, 0);
    chk("ones idx wrap", bit_idx_o, 0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("ones ack", cw_valid, 0);

    // abort an n=8 frame at i=100, then a short frame
    cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 100; j++) cyc(1'b0, 4'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    chk("abort idx100", bit_idx_o, 100);
    cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    chk("abort psum clr", psum_o, 0);
    chk("abort idx clr", bit_idx_o, 0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("abort cw", cw_o, 256'hB);
    chk("abort cw_valid", cw_valid, 1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // n_cfg clamping: 0 and 15 both mean n=8
    for (int c = 0; c < 2; c++) begin
      cyc(1'b1, ncase[c], 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 255; j++) cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("clamp%0d not done", ncase[c]), cw_valid, 0);
      chk($sformatf("clamp%0d idx255", ncase[c]), bit_idx_o, 255);
      cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("clamp%0d done", ncase[c]), cw_valid, 1);
      chk($sformatf("clamp%0d cw", ncase[c]), cw_o, top1);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    end

    // asynchronous reset at i=37
    cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 37; j++) cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("rst pre idx37", bit_idx_o, 37);
    rst_n = 1'b0;
    #1;
    chk("rst u_ready", u_ready, 0);
    chk("rst idx", bit_idx_o, 0);
    chk("rst psum", psum_o, 0);
    chk("rst upd", psum_upd_o, 0);
    chk("rst cw_valid", cw_valid, 0);
    chk("rst cw", cw_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("post rst%0d u_ready", j), u_ready, 0);
      chk($sformatf("post rst%0d idx", j), bit_idx_o, 0);
      chk($sformatf("post rst%0d psum", j), psum_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
